// File: rtl/mem_stage_pkg.sv
// Shared types and address decoding for the MIPS memory-stage controller.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_OUT = 2'd1,
        REG_IN  = 2'd2,
        REG_BAD = 2'd3
    } region_e;

    localparam logic [63:0] OUT_OFFS = 64'd0;
    localparam logic [63:0] IN_OFFS  = 64'd4;

    // Misaligned addresses fall into BAD before any range check.
    function automatic region_e region_of(input logic [63:0] addr,
                                          input logic [63:0] ram_bytes,
                                          input logic [63:0] io_base);
        region_e r;
        if (addr[1:0] != 2'b00) begin
            r = REG_BAD;
        end else if (addr < ram_bytes) begin
            r = REG_RAM;
        end else if (addr == io_base + OUT_OFFS) begin
            r = REG_OUT;
        end else if (addr == io_base + IN_OFFS) begin
            r = REG_IN;
        end else begin
            r = REG_BAD;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request/ready bus between the EX/MEM register (master) and the memory stage (slave).
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              err;

    modport master (output req, we, addr, wdata, input rdata, ready, err);
    modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/mem_stage_ram.sv
// Single-port synchronous data RAM; dout is registered one cycle after en.
module mem_stage_ram #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 1024,
    parameter int AW     = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] dout_q;

    // Storage array and read register; contents survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= din;
            end
            dout_q <= mem_q[addr];
        end
    end

    assign dout = dout_q;
endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: data RAM, memory-mapped OUT/IN ports and error response
// behind one request/ready bus.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter int              RAM_WORDS = 1024,
    parameter int              RAM_WAIT  = 1,
    parameter logic [ADDR_W-1:0] IO_BASE = 32'h0000_8000,
    parameter int              OUT_W     = 10,
    parameter int              IN_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_stage_ctrl_if.slave   bus,
    input  logic [IN_W-1:0]   in_port,
    output logic [OUT_W-1:0]  out_port
);
    localparam int WA_W = $clog2(RAM_WORDS);

    state_e             state_q, state_d;
    region_e            region_q, region_d, region_s;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [OUT_W-1:0]   wdata_q, wdata_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               err_out_q, err_out_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [IN_W-1:0]    sync1_q, sync2_q;
    logic               ram_en_s;
    logic [DATA_W-1:0]  ram_dout_s;
    logic [DATA_W-1:0]  resp_val_s;
    logic               resp_rd_ok_s;

    // Decode the live bus address; RAM access is launched on the IDLE sample edge.
    always_comb begin
        region_s = region_of(64'(bus.addr), 64'(RAM_WORDS) * 64'd4, 64'(IO_BASE));
        ram_en_s = (state_q == ST_IDLE) && bus.req && (region_s == REG_RAM);
    end

    mem_stage_ram #(.DATA_W(DATA_W), .WORDS(RAM_WORDS)) u_ram (
        .clk  (clk),
        .en   (ram_en_s),
        .we   (bus.we),
        .addr (bus.addr[WA_W+1:2]),
        .din  (bus.wdata),
        .dout (ram_dout_s)
    );

    // Next-state logic and request capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        region_d = region_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    region_d = region_s;
                    we_d     = bus.we;
                    wdata_d  = bus.wdata[OUT_W-1:0];
                    err_d    = (region_s == REG_BAD) || ((region_s == REG_IN) && bus.we);
                    if ((region_s == REG_RAM) && (RAM_WAIT != 0)) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(RAM_WAIT);
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // The WAIT state lasts exactly RAM_WAIT cycles.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response data, OUT register update and registered handshake flags.
    always_comb begin
        case (region_q)
            REG_RAM: resp_val_s = ram_dout_s;
            REG_OUT: resp_val_s = DATA_W'(out_q);
            REG_IN:  resp_val_s = DATA_W'(sync2_q);
            default: resp_val_s = {DATA_W{1'b0}};
        endcase
        resp_rd_ok_s = (state_q == ST_RESP) && !we_q && !err_q;
        rdata_d      = resp_rd_ok_s ? resp_val_s : rdata_q;
        if ((state_q == ST_RESP) && we_q && !err_q && (region_q == REG_OUT)) begin
            out_d = wdata_q;
        end else begin
            out_d = out_q;
        end
        ready_d   = (state_d == ST_RESP);
        err_out_d = (state_d == ST_RESP) ? err_d : 1'b0;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            region_q  <= REG_BAD;
            we_q      <= 1'b0;
            wdata_q   <= {OUT_W{1'b0}};
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            err_out_q <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
            out_q     <= {OUT_W{1'b0}};
            sync1_q   <= {IN_W{1'b0}};
            sync2_q   <= {IN_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            region_q  <= region_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            err_out_q <= err_out_d;
            rdata_q   <= rdata_d;
            out_q     <= out_d;
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
        end
    end

    // rdata bypasses its holding register only during a successful read response.
    assign bus.rdata = resp_rd_ok_s ? resp_val_s : rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_out_q;
    assign out_port  = out_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with RAM_WAIT = 1, 0 and 3 instances.
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [15:0] in_port = 16'd0;
    int          sel = 1;
    int          n_asrt = 0;
    int          n_fail = 0;

    logic        rdy_m, err_m;
    logic [31:0] rd_m;
    logic [9:0]  outp_m;
    logic [9:0]  outp0, outp1, outp3;

    always #5 clk = ~clk;

    mem_stage_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b0 ();
    mem_stage_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b1 ();
    mem_stage_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b3 ();

    assign b0.req = req && (sel == 0);
    assign b1.req = req && (sel == 1);
    assign b3.req = req && (sel == 3);
    assign b0.we = we;  assign b1.we = we;  assign b3.we = we;
    assign b0.addr = addr;  assign b1.addr = addr;  assign b3.addr = addr;
    assign b0.wdata = wdata;  assign b1.wdata = wdata;  assign b3.wdata = wdata;

    mem_stage_ctrl #(.RAM_WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0), .in_port(in_port), .out_port(outp0));
    mem_stage_ctrl #(.RAM_WAIT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1), .in_port(in_port), .out_port(outp1));
    mem_stage_ctrl #(.RAM_WAIT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3), .in_port(in_port), .out_port(outp3));

    always_comb begin
        case (sel)
            0:       begin rdy_m = b0.ready; err_m = b0.err; rd_m = b0.rdata; outp_m = outp0; end
            3:       begin rdy_m = b3.ready; err_m = b3.err; rd_m = b3.rdata; outp_m = outp3; end
            default: begin rdy_m = b1.ready; err_m = b1.err; rd_m = b1.rdata; outp_m = outp1; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts from the current negedge (cycle 1) until ready is seen.
    task automatic wait_ready(output int lat);
        lat = 1;
        while (!rdy_m) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (lat > 64) begin
                chk("ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic e);
        @(negedge clk);
        we = w; addr = a; wdata = d; req = 1'b1;
        wait_ready(lat);
        rd = rd_m;
        e  = err_m;
        req = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(rdy_m), 32'd0);
        chk("rst_err", 32'(err_m), 32'd0);
        chk("rst_rdata", rd_m, 32'd0);
        chk("rst_out", 32'(outp_m), 32'd0);
        rst = 1'b0;

        // RAM round trip, RAM_WAIT=1
        sel = 1;
        access(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e);
        chk("w1_lat", 32'(lat), 32'd3);
        chk("w1_err", 32'(e), 32'd0);
        access(1'b0, 32'h10, 32'h0, lat, rd, e);
        chk("r1_lat", 32'(lat), 32'd3);
        chk("r1_data", rd, 32'hDEADBEEF);
        chk("r1_err", 32'(e), 32'd0);

        // RAM_WAIT=0 and 3, last word
        sel = 0;
        access(1'b1, 32'hFFC, 32'hA5A50001, lat, rd, e);
        access(1'b0, 32'hFFC, 32'h0, lat, rd, e);
        chk("r0_lat", 32'(lat), 32'd2);
        chk("r0_data", rd, 32'hA5A50001);
        sel = 3;
        access(1'b1, 32'hFFC, 32'h12345678, lat, rd, e);
        access(1'b0, 32'hFFC, 32'h0, lat, rd, e);
        chk("r3_lat", 32'(lat), 32'd5);
        chk("r3_data", rd, 32'h12345678);

        // OUT / IN ports
        sel = 1;
        access(1'b1, 32'h8000, 32'hFFFFF2A5, lat, rd, e);
        chk("wout_lat", 32'(lat), 32'd2);
        chk("wout_err", 32'(e), 32'd0);
        @(negedge clk);
        chk("out_port", 32'(outp_m), 32'h2A5);
        access(1'b0, 32'h8000, 32'h0, lat, rd, e);
        chk("rout_data", rd, 32'h2A5);
        in_port = 16'h1234;
        repeat (2) @(negedge clk);
        access(1'b0, 32'h8004, 32'h0, lat, rd, e);
        chk("rin_lat", 32'(lat), 32'd2);
        chk("rin_data", rd, 32'h1234);

        // Error responses
        access(1'b0, 32'h12, 32'h0, lat, rd, e);
        chk("mis_err", 32'(e), 32'd1);
        chk("mis_rdata", rd, 32'h1234);
        access(1'b1, 32'h8004, 32'h0, lat, rd, e);
        chk("win_err", 32'(e), 32'd1);
        @(negedge clk);
        chk("win_out", 32'(outp_m), 32'h2A5);
        access(1'b0, 32'h8008, 32'h0, lat, rd, e);
        chk("unm_err", 32'(e), 32'd1);
        chk("unm_rdata", rd, 32'h1234);
        access(1'b0, 32'h1000, 32'h0, lat, rd, e);
        chk("oor_err", 32'(e), 32'd1);
        chk("oor_rdata", rd, 32'h1234);
        access(1'b1, 32'h11, 32'h55555555, lat, rd, e);
        chk("wmis_err", 32'(e), 32'd1);
        access(1'b0, 32'h10, 32'h0, lat, rd, e);
        chk("wmis_ram", rd, 32'hDEADBEEF);

        // Back-to-back writes with req held
        @(negedge clk);
        we = 1'b1; addr = 32'h0; wdata = 32'h11112222; req = 1'b1;
        wait_ready(lat);
        chk("b2b_lat1", 32'(lat), 32'd3);
        addr = 32'h4; wdata = 32'h33334444;
        @(negedge clk);
        chk("b2b_gap", 32'(rdy_m), 32'd0);
        wait_ready(lat);
        chk("b2b_lat2", 32'(lat), 32'd3);
        req = 1'b0;
        access(1'b1, 32'h1000, 32'hBAD0BAD0, lat, rd, e);
        chk("woor_err", 32'(e), 32'd1);
        access(1'b0, 32'h0, 32'h0, lat, rd, e);
        chk("b2b_rd0", rd, 32'h11112222);
        access(1'b0, 32'h4, 32'h0, lat, rd, e);
        chk("b2b_rd4", rd, 32'h33334444);

        // Reset mid-WAIT of a RAM read
        @(negedge clk);
        we = 1'b0; addr = 32'h10; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        #1;
        chk("mrst_ready", 32'(rdy_m), 32'd0);
        chk("mrst_rdata", rd_m, 32'd0);
        chk("mrst_out", 32'(outp_m), 32'd0);
        @(negedge clk);
        chk("mrst_idle", 32'(dut1.state_q == mem_stage_pkg::ST_IDLE), 32'd1);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mrst_noready", 32'(rdy_m), 32'd0);
        end
        access(1'b0, 32'h10, 32'h0, lat, rd, e);
        chk("mrst_ramkept", rd, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Parametrised memory-stage controller for the MIPS CPU.
- Combines word-addressed data RAM, address decoding and memory-mapped I/O behind one request/ready bus.
- Adds configurable RAM wait states, a registered output port, a synchronised input port and an error response.
- Sits between the EX/MEM pipeline register and the WB stage. The pipeline stalls while a request is outstanding.

Parameters:
DATA_W, 32, data bus width (multiple of 8)
ADDR_W, 32, byte address width
RAM_WORDS, 1024, data RAM depth in words (power of two)
RAM_WAIT, 1, extra RAM wait cycles (0..15)
IO_BASE, 32'h0000_8000, byte base of the I/O window (above RAM space)
OUT_W, 10, output port width
IN_W, 16, input port width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req  in  1  access request; held high until ready
we  in  1  1 = write, 0 = read; stable while req
addr  in  ADDR_W  byte address; stable while req
wdata  in  DATA_W  write data; stable while req
rdata  out  DATA_W  read data; valid when ready && !we && !err
ready  out  1  one-cycle completion pulse
err  out  1  error flag, valid with ready
in_port  in  IN_W  asynchronous external input (switches)
out_port  out  OUT_W  registered external output (LEDs)

Behaviour:
- Reset (async, rst=1): state IDLE; rdata=0, ready=0, err=0, out_port=0; wait counter=0; both input synchroniser stages=0. RAM contents are not cleared.
- Decode, word aligned (addr[1:0]==0):
  - addr < RAM_WORDS*4: RAM.
  - addr==IO_BASE: OUT register (R/W). Read returns zero-extended out_port. Write stores wdata[OUT_W-1:0].
  - addr==IO_BASE+4: IN register (RO). Read returns zero-extended synchronised in_port. Write sets err.
  - Anything else: unmapped, sets err.
- Misaligned (addr[1:0]!=0): err, no side effects.
- FSM IDLE, WAIT, RESP:
  - IDLE && req, RAM target: go WAIT, counter=RAM_WAIT. If RAM_WAIT==0, go directly to RESP.
  - IDLE && req, I/O, error, or misaligned target: go RESP.
  - WAIT: counter decrements each cycle. At 0, go RESP.
  - RESP: ready=1 for exactly one cycle, err set per decode. Then go IDLE.
- Req/we/addr/wdata are captured in IDLE. Changes while busy are ignored.
- RAM write: issued on the IDLE->WAIT/RESP transition. RAM read: data captured on entry to RESP.
- RAM latency: ready asserts RAM_WAIT+2 cycles after the req edge is sampled. I/O latency: 2 cycles.
- Back-to-back: if req is still high in the cycle after ready, it is a new request. The master must drop req on ready if it has no new access.
- rdata: updated only on successful reads. Holds its value otherwise; unchanged on writes and on errors.
- out_port: updates on the RESP cycle of a successful OUT write.
- in_port: two-flop synchroniser. The IN read samples the second stage in the RESP cycle.
- Reset mid-operation:
  - Aborts to IDLE with no ready pulse.
  - A RAM write already issued stays written.
  - A pending OUT write is lost.
- req low in IDLE: no activity, ready=0.

Decomposition:
- Package mem_stage_pkg:
  - state typedef (IDLE/WAIT/RESP);
  - region typedef (RAM/OUT/IN/BAD);
  - OUT_OFFS=0, IN_OFFS=4;
  - decode function region_of(addr).
- Sub-module mem_stage_ram:
  - single-port synchronous RAM, RAM_WORDS x DATA_W;
  - ports clk, en, we, word addr, din, dout;
  - dout registered one cycle after en.
- The FSM, decoder, I/O registers and synchroniser stay in mem_stage_ctrl.

Test Plan:
- Reset: assert rst mid-WAIT of a RAM read -> ready never pulses; rdata=0, out_port=0, state IDLE next cycle.
- RAM round trip, RAM_WAIT=1: write 0xDEADBEEF to 0x10, read 0x10 -> each ready 3 cycles after req; rdata=0xDEADBEEF, err=0.
- RAM_WAIT=0 vs 3: read latency is 2 and 5 cycles respectively; the last RAM word (RAM_WORDS*4-4) is accessible.
- OUT/IN ports:
  - write 0xFFFF_F2A5 to IO_BASE -> out_port=10'h2A5; read IO_BASE -> rdata=0x2A5.
  - set in_port=16'h1234, wait 2 cycles, read IO_BASE+4 -> rdata=0x1234.
- Errors: each of the following gives ready=1, err=1, rdata unchanged, and no RAM/out_port change:
  - read 0x12 (misaligned);
  - write IO_BASE+4;
  - read IO_BASE+8;
  - read RAM_WORDS*4.
- Back-to-back: hold req high across two RAM writes to 0x0 and 0x4 -> two distinct ready pulses; both words read back correctly.
